// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the generative-music MIDI chain.
//   MIDI_NOTE_W  : width of a MIDI note / velocity data byte (7 bits)
//   MIDI_VEL_OFF : velocity that turns a note-on into a note-off
//   ngs_state_e  : note_gate_scheduler FSM states
//   DRAIN_SKIP   : cycles after a trigger during which the sender's busy
//                  flag is not yet trustworthy
// -----------------------------------------------------------------------------
package midi_pkg;

    localparam int MIDI_NOTE_W = 7;

    localparam logic [MIDI_NOTE_W-1:0] MIDI_VEL_OFF = 7'd0;

    // The trigger cycle itself and the following cycle are skipped before
    // busy is trusted, because the sender only raises busy one cycle late.
    localparam logic [1:0] DRAIN_SKIP = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ON_REQ    = 3'd1,
        ST_ON_DRAIN  = 3'd2,
        ST_GATE      = 3'd3,
        ST_OFF_REQ   = 3'd4,
        ST_OFF_DRAIN = 3'd5
    } ngs_state_e;

endpackage

// File: rtl/gate_timer.sv
// -----------------------------------------------------------------------------
// gate_timer
// Loadable down-counter that times the note gate.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_val this cycle (has priority over en)
//   load_val   : value to load
//   en         : decrement by one; the counter stops at 0 and never wraps
//   done       : count is 0
// -----------------------------------------------------------------------------
module gate_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/note_gate_scheduler.sv
// -----------------------------------------------------------------------------
// note_gate_scheduler
// Turns single-cycle note requests into a note-on / note-off pair paced
// against the MIDI sender's busy handshake, with a one-deep pending buffer
// so a note arriving mid-gate retriggers cleanly.
//   GATE_CYCLES   : cycles from note-on completion to note-off request (>= 1)
//   VELOCITY      : note-on velocity (1..127)
//   clk, rst_n    : clock, asynchronous active-low reset
//   note_valid    : single-cycle new-note request
//   note_in       : MIDI note number, bit 7 ignored
//   busy          : sender is transmitting
//   send_trigger  : single-cycle pulse to the sender
//   send_note     : note for the sender, bit 7 always 0
//   send_velocity : VELOCITY for note-on, 0 for note-off
//   gate_active   : high from note-on trigger until note-off trigger
//   dropped       : pulses when a pending note is overwritten
// -----------------------------------------------------------------------------
module note_gate_scheduler
    import midi_pkg::*;
#(
    parameter int GATE_CYCLES = 2_700_000,
    parameter int VELOCITY    = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       note_valid,
    input  logic [7:0] note_in,
    input  logic       busy,
    output logic       send_trigger,
    output logic [7:0] send_note,
    output logic [6:0] send_velocity,
    output logic       gate_active,
    output logic       dropped
);

    localparam int TMR_W = $clog2(GATE_CYCLES + 1);
    localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(GATE_CYCLES - 1);
    localparam logic [MIDI_NOTE_W-1:0] VEL_ON = MIDI_NOTE_W'(VELOCITY);

    ngs_state_e             state_d,        state_q;
    logic [MIDI_NOTE_W-1:0] cur_note_d,     cur_note_q;
    logic [MIDI_NOTE_W-1:0] pend_note_d,    pend_note_q;
    logic                   pend_vld_d,     pend_vld_q;
    logic [1:0]             drain_cnt_d,    drain_cnt_q;
    logic                   send_trigger_d, send_trigger_q;
    logic [MIDI_NOTE_W-1:0] send_note_d,    send_note_q;
    logic [MIDI_NOTE_W-1:0] send_vel_d,     send_vel_q;
    logic                   gate_active_d,  gate_active_q;
    logic                   dropped_d,      dropped_q;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_done;
    logic             drain_done;
    logic             note_msb_unused;

    assign note_msb_unused = note_in[7];

    // The sender has finished once the skip window is over and busy is low.
    assign drain_done = (drain_cnt_q == 2'd0) && !busy;
    assign tmr_en     = (state_q == ST_GATE);

    gate_timer #(
        .W (TMR_W)
    ) u_gate_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_comb begin
        state_d        = state_q;
        cur_note_d     = cur_note_q;
        pend_note_d    = pend_note_q;
        pend_vld_d     = pend_vld_q;
        drain_cnt_d    = drain_cnt_q;
        send_trigger_d = 1'b0;
        send_note_d    = send_note_q;
        send_vel_d     = send_vel_q;
        gate_active_d  = gate_active_q;
        dropped_d      = 1'b0;
        tmr_load       = 1'b0;
        tmr_val        = '0;

        if (drain_cnt_q != 2'd0) begin
            drain_cnt_d = drain_cnt_q - 2'd1;
        end

        // Outside IDLE every new note lands in the pending buffer; the last
        // one wins and an overwrite is flagged.
        if (note_valid && (state_q != ST_IDLE)) begin
            pend_note_d = note_in[MIDI_NOTE_W-1:0];
            pend_vld_d  = 1'b1;
            dropped_d   = pend_vld_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (note_valid) begin
                    cur_note_d = note_in[MIDI_NOTE_W-1:0];
                    state_d    = ST_ON_REQ;
                end
            end
            ST_ON_REQ: begin
                if (!busy) begin
                    send_trigger_d = 1'b1;
                    send_note_d    = cur_note_q;
                    send_vel_d     = VEL_ON;
                    gate_active_d  = 1'b1;
                    drain_cnt_d    = DRAIN_SKIP;
                    state_d        = ST_ON_DRAIN;
                end
            end
            ST_ON_DRAIN: begin
                if (drain_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = GATE_LOAD;
                    state_d  = ST_GATE;
                end
            end
            ST_GATE: begin
                // A waiting note cuts the gate short. Clearing the timer on
                // exit keeps it at 0 whenever the FSM is outside GATE.
                if (tmr_done || pend_vld_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = '0;
                    state_d  = ST_OFF_REQ;
                end
            end
            ST_OFF_REQ: begin
                if (!busy) begin
                    send_trigger_d = 1'b1;
                    send_note_d    = cur_note_q;
                    send_vel_d     = MIDI_VEL_OFF;
                    gate_active_d  = 1'b0;
                    drain_cnt_d    = DRAIN_SKIP;
                    state_d        = ST_OFF_DRAIN;
                end
            end
            ST_OFF_DRAIN: begin
                if (drain_done) begin
                    if (pend_vld_q) begin
                        // Pending moves to current; a note arriving now takes
                        // the freed slot without counting as a drop.
                        cur_note_d = pend_note_q;
                        pend_vld_d = note_valid;
                        dropped_d  = 1'b0;
                        state_d    = ST_ON_REQ;
                    end else if (note_valid) begin
                        // Same-cycle arrival is treated as if it came in IDLE.
                        cur_note_d = note_in[MIDI_NOTE_W-1:0];
                        pend_vld_d = 1'b0;
                        state_d    = ST_ON_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cur_note_q     <= '0;
            pend_note_q    <= '0;
            pend_vld_q     <= 1'b0;
            drain_cnt_q    <= 2'd0;
            send_trigger_q <= 1'b0;
            send_note_q    <= '0;
            send_vel_q     <= '0;
            gate_active_q  <= 1'b0;
            dropped_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_note_q     <= cur_note_d;
            pend_note_q    <= pend_note_d;
            pend_vld_q     <= pend_vld_d;
            drain_cnt_q    <= drain_cnt_d;
            send_trigger_q <= send_trigger_d;
            send_note_q    <= send_note_d;
            send_vel_q     <= send_vel_d;
            gate_active_q  <= gate_active_d;
            dropped_q      <= dropped_d;
        end
    end

    assign send_trigger  = send_trigger_q;
    assign send_note     = {1'b0, send_note_q};
    assign send_velocity = send_vel_q;
    assign gate_active   = gate_active_q;
    assign dropped       = dropped_q;

endmodule

// File: tb/tb_note_gate_scheduler.sv
// -----------------------------------------------------------------------------
// tb_note_gate_scheduler
// Directed bench for note_gate_scheduler with GATE_CYCLES = 20. A sender
// model holds busy high for 30 cycles starting the cycle after each trigger.
// Stimulus pushes the expected trigger stream (note, velocity, cycle) into a
// queue; a monitor pops and compares on every send_trigger.
//
// Hand-derived timing for a note requested in cycle c with the sender idle:
//   note-on  at c+2  (latch cycle, ON_REQ cycle)
//   ON_DRAIN occupies 32 cycles (busy high 30 cycles from the cycle after
//   the trigger), GATE 20 cycles, OFF_REQ 1 cycle -> note-off at c+55
//   the note-off drain completes at c+86; back in IDLE at c+87
// -----------------------------------------------------------------------------
module tb_note_gate_scheduler;

    localparam int GATE     = 20;
    localparam int VEL      = 100;
    localparam int BUSY_LEN = 30;

    typedef struct {
        logic [7:0] note;
        logic [6:0] vel;
        int         cyc;
    } exp_t;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       note_valid = 1'b0;
    logic [7:0] note_in    = 8'd0;
    logic       busy;
    logic       busy_force = 1'b0;
    logic       send_trigger;
    logic [7:0] send_note;
    logic [6:0] send_velocity;
    logic       gate_active;
    logic       dropped;

    int cyc           = 0;
    int busy_cnt      = 0;
    int n_vec         = 0;
    int n_err         = 0;
    int drop_cnt      = 0;
    int last_drop_cyc = -1;

    exp_t exp_q[$];

    note_gate_scheduler #(
        .GATE_CYCLES (GATE),
        .VELOCITY    (VEL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .note_valid    (note_valid),
        .note_in       (note_in),
        .busy          (busy),
        .send_trigger  (send_trigger),
        .send_note     (send_note),
        .send_velocity (send_velocity),
        .gate_active   (gate_active),
        .dropped       (dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sender model: busy from T+1 to T+BUSY_LEN for a trigger seen in cycle T.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 0;
        end else if (send_trigger) begin
            busy_cnt <= BUSY_LEN;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign busy = busy_force | (busy_cnt != 0);

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_trig(input logic [7:0] n, input logic [6:0] v, input int c);
        exp_t e;
        e.note = n;
        e.vel  = v;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic goto_cycle(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic note_at(input int k, input logic [7:0] n);
        goto_cycle(k);
        note_in    = n;
        note_valid = 1'b1;
        @(negedge clk);
        note_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_send_trigger"},  int'(send_trigger),  0);
        check({tag, "_send_note"},     int'(send_note),     0);
        check({tag, "_send_velocity"}, int'(send_velocity), 0);
        check({tag, "_gate_active"},   int'(gate_active),   0);
        check({tag, "_dropped"},       int'(dropped),       0);
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dropped) begin
                    drop_cnt++;
                    last_drop_cyc = cyc;
                end
                if (send_trigger) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_trigger_note", int'(send_note), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("trig_note",        int'(send_note),     int'(e.note));
                        check("trig_velocity",    int'(send_velocity), int'(e.vel));
                        check("trig_cycle",       cyc,                 e.cyc);
                        check("trig_gate_active", int'(gate_active),   (e.vel != 7'd0) ? 1 : 0);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int c;
        int d0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single note, bit 7 of note_in set and ignored
        c  = cyc + 2;
        d0 = drop_cnt;
        expect_trig(8'd60, 7'(VEL), c + 2);
        expect_trig(8'd60, 7'd0,    c + 55);
        note_at(c, 8'd188);
        goto_cycle(c + 30);
        check("t1_gate_active_mid", int'(gate_active), 1);
        goto_cycle(c + 100);
        check("t1_gate_active_end", int'(gate_active),   0);
        check("t1_hold_note",       int'(send_note),     60);
        check("t1_hold_velocity",   int'(send_velocity), 0);
        check("t1_drops",           drop_cnt - d0,       0);

        // 2: retrigger during GATE
        c  = cyc + 2;
        d0 = drop_cnt;
        expect_trig(8'd60, 7'(VEL), c + 2);
        expect_trig(8'd60, 7'd0,    c + 45);
        expect_trig(8'd64, 7'(VEL), c + 78);
        expect_trig(8'd64, 7'd0,    c + 131);
        note_at(c, 8'd60);
        note_at(c + 42, 8'd64);
        goto_cycle(c + 170);
        check("t2_drops", drop_cnt - d0, 0);

        // 3: two notes during ON_DRAIN, the first is overwritten
        c  = cyc + 2;
        d0 = drop_cnt;
        expect_trig(8'd60, 7'(VEL), c + 2);
        expect_trig(8'd60, 7'd0,    c + 36);
        expect_trig(8'd67, 7'(VEL), c + 69);
        expect_trig(8'd67, 7'd0,    c + 122);
        note_at(c, 8'd60);
        note_at(c + 10, 8'd64);
        note_at(c + 15, 8'd67);
        goto_cycle(c + 160);
        check("t3_drops",      drop_cnt - d0, 1);
        check("t3_drop_cycle", last_drop_cyc, c + 16);

        // 4: sender busy for 100 cycles before the note
        c = cyc + 2;
        expect_trig(8'd72, 7'(VEL), c + 101);
        expect_trig(8'd72, 7'd0,    c + 154);
        goto_cycle(c);
        busy_force = 1'b1;
        note_at(c + 5, 8'd72);
        goto_cycle(c + 50);
        check("t4_gate_active_wait", int'(gate_active), 0);
        goto_cycle(c + 100);
        busy_force = 1'b0;
        goto_cycle(c + 200);

        // 5: note arrives in the cycle the gate counter reaches 0
        c  = cyc + 2;
        d0 = drop_cnt;
        expect_trig(8'd60, 7'(VEL), c + 2);
        expect_trig(8'd60, 7'd0,    c + 55);
        expect_trig(8'd62, 7'(VEL), c + 88);
        expect_trig(8'd62, 7'd0,    c + 141);
        note_at(c, 8'd60);
        note_at(c + 53, 8'd62);
        goto_cycle(c + 180);
        check("t5_drops", drop_cnt - d0, 0);

        // 6: note arrives in the OFF_DRAIN -> IDLE decision cycle
        c = cyc + 2;
        expect_trig(8'd60, 7'(VEL), c + 2);
        expect_trig(8'd60, 7'd0,    c + 55);
        expect_trig(8'd69, 7'(VEL), c + 88);
        expect_trig(8'd69, 7'd0,    c + 141);
        note_at(c, 8'd60);
        note_at(c + 86, 8'd69);
        goto_cycle(c + 180);

        // 7: asynchronous reset during GATE, then a fresh note
        c = cyc + 2;
        expect_trig(8'd65, 7'(VEL), c + 2);
        note_at(c, 8'd65);
        goto_cycle(c + 40);
        check("t7_gate_active_pre", int'(gate_active), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t7_async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        c = cyc + 2;
        expect_trig(8'd67, 7'(VEL), c + 2);
        expect_trig(8'd67, 7'd0,    c + 55);
        note_at(c, 8'd67);
        goto_cycle(c + 100);
        check("t7_gate_active_end", int'(gate_active), 0);

        check("expectations_left", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/note_gate_scheduler.md
# note_gate_scheduler

Sits between the sequencer and `midi_note_sender` in the generative-music chain. It turns each single-cycle note pulse into a timed note pair: note-on at a fixed velocity, then note-on with velocity 0 (MIDI note-off) after a programmable gate time. It paces both messages against the sender's `busy` handshake and holds one pending note, so overlapping notes retrigger cleanly instead of leaving notes hanging.

## Interface
- `GATE_CYCLES`, default 2_700_000: clock cycles between note-on completion and note-off trigger (100 ms at 27 MHz); must be ≥ 1.
- `VELOCITY`, default 100: note-on velocity; must be 1..127.
- `clk`  in  1  system clock; the block has one clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `note_valid`  in  1  single-cycle pulse; a new note is requested.
- `note_in`  in  8  MIDI note number; bit 7 is ignored.
- `busy`  in  1  `midi_note_sender` is transmitting.
- `send_trigger`  out  1  single-cycle pulse to the sender.
- `send_note`  out  8  note for the sender; bit 7 is always 0.
- `send_velocity`  out  7  `VELOCITY` for note-on, 0 for note-off.
- `gate_active`  out  1  high from note-on trigger until note-off trigger.
- `dropped`  out  1  single-cycle pulse when a pending note is overwritten.

## Operation
- Reset values: all outputs 0, FSM in IDLE, pending buffer empty, gate counter 0.
- FSM states and transitions:
  - IDLE → ON_REQ on `note_valid`; the current note is latched from `note_in[6:0]`.
  - ON_REQ: wait for `busy` == 0. Then pulse `send_trigger` with `send_velocity` = `VELOCITY`, set `gate_active`, and go to ON_DRAIN.
  - ON_DRAIN: wait for sender completion (see Timing), then → GATE.
  - GATE: load the counter with `GATE_CYCLES`−1 and count down. Go to OFF_REQ when the counter reaches 0, or immediately if the pending buffer is occupied (retrigger).
  - OFF_REQ: wait for `busy` == 0. Then pulse `send_trigger` with velocity 0 and the current note, clear `gate_active`, and go to OFF_DRAIN.
  - OFF_DRAIN: wait for completion. If pending is occupied, move pending to current, clear pending, and go to ON_REQ; otherwise go to IDLE.
- `note_valid` in any state other than IDLE writes the pending buffer.
  - If pending is already full, the new note overwrites it (last wins) and `dropped` pulses in the same cycle.
  - `note_valid` in IDLE goes directly to current; pending is untouched.
- Simultaneous events:
  - `note_valid` in the cycle the gate counter hits 0: the note is captured as pending, and note-off is followed by note-on of the pending note.
  - `note_valid` in the same cycle as the OFF_DRAIN→IDLE decision: the note is captured into current, and the FSM goes to ON_REQ instead of IDLE.
- `send_note` and `send_velocity` are registered. They change only in the cycle `send_trigger` asserts and hold their value otherwise.
- Reset mid-operation clears everything asynchronously. No all-notes-off is emitted, so a sounding note may hang; this is accepted.

## Timing
- `note_valid` in IDLE with `busy` low: `send_trigger` at T+2 (one cycle latch, one cycle ON_REQ).
- Drain rule: for a trigger at cycle T, `busy` is ignored in T+1. Completion is the first cycle ≥ T+2 with `busy` == 0. This requires the sender to raise `busy` by T+1.
- Note-on trigger to note-off trigger, sender idle: drain time + `GATE_CYCLES` + 1 cycle.
- Retrigger with the sender idle: note-off is triggered on the first cycle after pending becomes set while in GATE, plus the OFF_REQ cycle.
- The gate counter width is `$clog2(GATE_CYCLES+1)`. It is unsigned and never wraps; it holds at 0 outside GATE.

## Structure
- Shared package `midi_pkg`:
  - FSM state enum.
  - `MIDI_VEL_OFF` = 7'd0.
  - `MIDI_NOTE_W` = 7.
- One sub-module, `gate_timer`: a loadable down-counter with `load`, `en`, and a `done` flag (`count` == 0). The FSM, pending buffer and output registers stay in `note_gate_scheduler`.
- Instantiated in the sequencer top between `seq_player` (`pulse_send_note`, `midi_note`) and `midi_note_sender` (`trigger`, `note`, `velocity`, `busy`).

## Test plan
Bench uses `GATE_CYCLES`=20 and a sender model whose `busy` is high for 30 cycles starting at T+1.
- Single note 60 in IDLE → trigger at T+2 with note 60, velocity 100; note-off (note 60, velocity 0) exactly 20 cycles after busy falls plus 1; return to IDLE; `gate_active` matches.
- Note 64 arrives during GATE of note 60 → immediate off(60) then on(64); no `dropped`.
- Notes 64 then 67 both arrive during ON_DRAIN of 60 → `dropped` pulses once; sequence is off(60), on(67); 64 never sent.
- `busy` held high for 100 cycles before the first note → no trigger while busy; trigger on the first cycle after busy falls.
- `note_valid` in the cycle the counter hits 0 → off(current) followed by on(new), never IDLE in between.
- `rst_n` pulsed low during GATE → all outputs 0 asynchronously; the next note behaves as a fresh single note.
